dpram_stream_reader: RTL and testbench

DPRAM_STREAM_READER -- requirements
Module: DPRAM_STREAM_READER

---
 rtl/dpram_stream_reader.sv | 177 +++++++++++++++++
 tb/tb_dpram_stream_reader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_stream_reader.sv
// Purpose : streams LEN consecutive words from one DPRAM read port onto a valid/ready beat stream.
// Latency : iSTART sampled at E0 -> first read issued before E1 -> first oVALID after E2; then 1 beat/cycle.
// Backpr. : a 2-entry output buffer plus at most one in-flight read; reads pause while iREADY is low.
//
// Ports:
//   iCLK, iRST          clock (rising edge) and asynchronous active-high reset
//   iSTART/iBASE/iLEN   command strobe, first word address, word count (sampled in IDLE only)
//   iABORT              cancel the running transfer (flush, no oDONE)
//   oBUSY/oDONE         not-idle status / one-cycle completion pulse
//   oRAM_ADDR/oRAM_WR   read port address (registered) and write enable (always 0)
//   iRAM_RDATA          read data, valid one edge after the address was sampled
//   oVALID/oDATA/oLAST  output stream; oLAST marks beat number LEN
//   iREADY              downstream accept
module dpram_stream_reader #(
    parameter int DBW   = 32,
    parameter int DEPTH = 1023,
    localparam int ABW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LBW  = ABW + 1
) (
    input  logic           iCLK,
    input  logic           iRST,
    input  logic           iSTART,
    input  logic [ABW-1:0] iBASE,
    input  logic [LBW-1:0] iLEN,
    input  logic           iABORT,
    output logic           oBUSY,
    output logic           oDONE,
    output logic [ABW-1:0] oRAM_ADDR,
    output logic           oRAM_WR,
    input  logic [DBW-1:0] iRAM_RDATA,
    output logic           oVALID,
    output logic [DBW-1:0] oDATA,
    output logic           oLAST,
    input  logic           iREADY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [ABW-1:0] r_addr;
    logic [LBW-1:0] r_remain;
    logic           r_inflight;
    logic           r_inflight_last;
    logic           r_done;

    // Two-entry output buffer, FIFO ordered by write/read pointers.
    logic [DBW-1:0] r_buf_dat  [2];
    logic           r_buf_last [2];
    logic           r_wp;
    logic           r_rp;
    logic [1:0]     r_cnt;

    logic           w_pop;
    logic           w_issue;
    logic           w_abort;
    logic           w_start;
    logic           w_last_acc;
    logic           w_rem_one;
    logic [2:0]     w_occ;
    logic [ABW-1:0] w_addr_nxt;

    assign w_pop      = oVALID & iREADY;
    assign w_abort    = iABORT & (r_state != S_IDLE);
    assign w_start    = (r_state == S_IDLE) & iSTART & ~iABORT;
    assign w_last_acc = w_pop & r_buf_last[r_rp];
    assign w_rem_one  = (r_remain == LBW'(1));

    // Occupancy seen by the next read: buffered + in flight, minus the beat leaving now.
    // Keeping this below 2 guarantees a free buffer slot when the read data lands.
    assign w_occ   = 3'(r_cnt) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue = (r_state == S_RUN) & (r_remain != '0) & (w_occ < 3'd2);

    assign w_addr_nxt = (r_addr == ABW'(DEPTH - 1)) ? '0 : r_addr + ABW'(1);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start && (iLEN != '0)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_issue && w_rem_one) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_abort || w_last_acc) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_addr          <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
            r_wp            <= 1'b0;
            r_rp            <= 1'b0;
            r_cnt           <= '0;
            for (int i = 0; i < 2; i++) begin
                r_buf_dat[i]  <= '0;
                r_buf_last[i] <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                // Drop buffered beats and the pending read; the RAM word that
                // arrives next edge is never captured because r_inflight clears.
                r_remain   <= '0;
                r_inflight <= 1'b0;
                r_wp       <= 1'b0;
                r_rp       <= 1'b0;
                r_cnt      <= '0;
            end else begin
                if (w_start) begin
                    if (iLEN == '0) begin
                        r_done <= 1'b1;
                    end else begin
                        r_addr   <= iBASE;
                        r_remain <= iLEN;
                    end
                end
                if (w_issue) begin
                    r_addr   <= w_addr_nxt;
                    r_remain <= r_remain - LBW'(1);
                end
                // The last tag travels with the read so the buffer knows which beat ends the transfer.
                r_inflight      <= w_issue;
                r_inflight_last <= w_issue & w_rem_one;
                if (r_inflight) begin
                    r_buf_dat[r_wp]  <= iRAM_RDATA;
                    r_buf_last[r_wp] <= r_inflight_last;
                    r_wp             <= ~r_wp;
                end
                if (w_pop) begin
                    r_rp <= ~r_rp;
                end
                r_cnt <= r_cnt + 2'(r_inflight) - 2'(w_pop);
                if (w_last_acc) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign oBUSY     = (r_state != S_IDLE);
    assign oDONE     = r_done;
    assign oRAM_ADDR = r_addr;
    assign oRAM_WR   = 1'b0;
    assign oVALID    = (r_cnt != 2'd0);
    assign oDATA     = r_buf_dat[r_rp];
    assign oLAST     = oVALID & r_buf_last[r_rp];

endmodule

// File: tb/tb_dpram_stream_reader.sv
module tb_dpram_stream_reader;

    localparam int DBW   = 32;
    localparam int DEPTH = 1023;
    localparam int ABW   = $clog2(DEPTH);
    localparam int LBW   = ABW + 1;

    logic           iCLK;
    logic           iRST;
    logic           iSTART;
    logic [ABW-1:0] iBASE;
    logic [LBW-1:0] iLEN;
    logic           iABORT;
    logic           oBUSY;
    logic           oDONE;
    logic [ABW-1:0] oRAM_ADDR;
    logic           oRAM_WR;
    logic [DBW-1:0] iRAM_RDATA;
    logic           oVALID;
    logic [DBW-1:0] oDATA;
    logic           oLAST;
    logic           iREADY;

    dpram_stream_reader #(.DBW(DBW), .DEPTH(DEPTH)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iBASE(iBASE), .iLEN(iLEN),
        .iABORT(iABORT), .oBUSY(oBUSY), .oDONE(oDONE), .oRAM_ADDR(oRAM_ADDR),
        .oRAM_WR(oRAM_WR), .iRAM_RDATA(iRAM_RDATA), .oVALID(oVALID), .oDATA(oDATA),
        .oLAST(oLAST), .iREADY(iREADY)
    );

    typedef struct packed {
        logic [DBW-1:0] d;
        logic           l;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          beats = 0;
    int          cyc   = 0;
    int          rdy_mode = 0;
    int          rdy_idx  = 0;
    logic [DBW-1:0] mem [DEPTH];

    // Monitor state
    bit             exp_done   = 0;
    bit             new_done   = 0;
    bit             stall      = 0;
    logic [DBW-1:0] stall_dat  = '0;
    bit             stall_last = 0;
    exp_t           m_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    // Memory holds its own address, so each expected word is just (base+i) mod DEPTH.
    initial begin
        for (int a = 0; a < DEPTH; a++) mem[a] = DBW'(a);
    end

    always @(posedge iCLK) begin
        iRAM_RDATA <= mem[oRAM_ADDR];
        cyc        <= cyc + 1;
    end

    // Ready driver: 0 always, 1 pattern 1,0,0,1, 2 random, 3 never
    initial begin
        iREADY = 1'b1;
        forever begin
            @(posedge iCLK);
            #1;
            rdy_idx++;
            case (rdy_mode)
                0: iREADY = 1'b1;
                1: iREADY = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
                2: iREADY = 1'($urandom_range(0, 1));
                default: iREADY = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted beat and checks done/stall rules.
    always @(negedge iCLK) begin
        if (iRST) begin
            q.delete();
            exp_done = 0;
            stall    = 0;
        end else begin
            chk("done_pulse", oDONE, exp_done);
            if (oDONE) chk("busy_at_done", oBUSY, 0);
            chk("ram_wr", oRAM_WR, 0);
            chk("addr_range", oRAM_ADDR < ABW'(DEPTH), 1);
            if (stall) begin
                chk("stall_valid", oVALID, 1);
                chk("stall_data", oDATA, stall_dat);
                chk("stall_last", oLAST, stall_last);
            end
            if (q.size() == 0) chk("spurious_valid", oVALID, 0);
            new_done = 0;
            if (iABORT && oBUSY) begin
                q.delete();
                stall = 0;
            end else if (oVALID && iREADY && q.size() > 0) begin
                m_e = q.pop_front();
                chk("beat_data", oDATA, m_e.d);
                chk("beat_last", oLAST, m_e.l);
                beats++;
                new_done = m_e.l;
                stall = 0;
            end else if (oVALID) begin
                stall      = 1;
                stall_dat  = oDATA;
                stall_last = oLAST;
            end else begin
                stall = 0;
            end
            if (iSTART && !oBUSY && !iABORT && iLEN == '0) new_done = 1;
            exp_done = new_done;
        end
    end

    task automatic push_exp(input int base, input int len);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.d = DBW'((base + i) % DEPTH);
            e.l = (i == len - 1);
            q.push_back(e);
        end
    endtask

    task automatic run_xfer(input int base, input int len, input int mode, input bit ign);
        int c0;
        int miss;
        int guard;
        bit seen;
        logic [ABW-1:0] a0;
        rdy_mode = mode;
        push_exp(base, len);
        @(posedge iCLK); #1;
        a0     = oRAM_ADDR;
        iSTART = 1'b1;
        iBASE  = ABW'(base);
        iLEN   = LBW'(len);
        @(posedge iCLK); #1;
        c0 = cyc;
        if (ign) begin
            iSTART = 1'b1;
            iBASE  = ABW'(300);
            iLEN   = '0;
        end else begin
            iSTART = 1'b0;
        end
        if (len == 0) begin
            chk("zlen_busy", oBUSY, 0);
            chk("zlen_done", oDONE, 1);
            repeat (3) @(posedge iCLK);
            #1;
            chk("zlen_addr", oRAM_ADDR, a0);
            return;
        end
        seen  = 0;
        guard = 0;
        while (!seen && guard < 10) begin
            if (oVALID) begin
                seen = 1;
            end else begin
                @(posedge iCLK); #1;
                iSTART = 1'b0;
                guard++;
            end
        end
        iSTART = 1'b0;
        chk("first_valid_seen", seen, 1);
        chk("latency", cyc - c0, 2);
        if (mode == 0) begin
            miss = 0;
            for (int i = 1; i < len; i++) begin
                @(posedge iCLK); #1;
                if (!oVALID) miss++;
            end
            chk("throughput_gaps", miss, 0);
        end
        guard = 0;
        while (oBUSY && guard < 8 * len + 50) begin
            @(posedge iCLK); #1;
            guard++;
        end
        chk("end_busy", oBUSY, 0);
        @(posedge iCLK); #1;
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin
        int b0;
        int guard;
        iRST   = 1'b1;
        iSTART = 1'b0;
        iBASE  = '0;
        iLEN   = '0;
        iABORT = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_busy", oBUSY, 0);
        chk("rst_done", oDONE, 0);
        chk("rst_valid", oVALID, 0);
        chk("rst_last", oLAST, 0);
        chk("rst_data", oDATA, 0);
        chk("rst_addr", oRAM_ADDR, 0);
        iRST = 1'b0;

        run_xfer(10, 4, 0, 0);
        run_xfer(1021, 4, 0, 0);
        run_xfer(0, 8, 1, 0);
        run_xfer(0, 0, 0, 0);
        run_xfer(200, 6, 0, 1);

        // Abort in IDLE does nothing and blocks a same-cycle start
        @(posedge iCLK); #1;
        iSTART = 1'b1; iBASE = ABW'(3); iLEN = LBW'(5); iABORT = 1'b1;
        @(posedge iCLK); #1;
        chk("idle_abort_busy", oBUSY, 0);
        iLEN = '0;
        @(posedge iCLK); #1;
        iSTART = 1'b0; iABORT = 1'b0;
        chk("idle_abort_zlen_done", oDONE, 0);

        // Abort on the 5th beat of a long transfer
        rdy_mode = 0;
        push_exp(600, 100);
        @(posedge iCLK); #1;
        iSTART = 1'b1; iBASE = ABW'(600); iLEN = LBW'(100);
        @(posedge iCLK); #1;
        iSTART = 1'b0;
        b0 = beats;
        guard = 0;
        while (beats != b0 + 4 && guard < 50) begin
            @(posedge iCLK); #1;
            guard++;
        end
        chk("abort_reach", beats - b0, 4);
        iABORT = 1'b1;
        @(posedge iCLK); #1;
        iABORT = 1'b0;
        chk("abort_valid", oVALID, 0);
        chk("abort_busy", oBUSY, 0);
        @(posedge iCLK); #1;
        chk("abort_no_done", oDONE, 0);
        chk("abort_flushed", q.size(), 0);
        run_xfer(50, 2, 0, 0);

        // Reset in DRAIN with a beat held by backpressure
        rdy_mode = 3;
        push_exp(7, 2);
        @(posedge iCLK); #1;
        iSTART = 1'b1; iBASE = ABW'(7); iLEN = LBW'(2);
        @(posedge iCLK); #1;
        iSTART = 1'b0;
        repeat (6) @(posedge iCLK);
        #1;
        chk("pre_rst_valid", oVALID, 1);
        chk("pre_rst_busy", oBUSY, 1);
        #2;
        iRST = 1'b1;
        #1;
        chk("async_rst_valid", oVALID, 0);
        chk("async_rst_busy", oBUSY, 0);
        chk("async_rst_addr", oRAM_ADDR, 0);
        chk("async_rst_data", oDATA, 0);
        @(posedge iCLK); #1;
        iRST = 1'b0;
        rdy_mode = 0;
        repeat (8) @(posedge iCLK);
        #1;
        chk("post_rst_idle", oBUSY, 0);

        for (int k = 0; k < 10; k++) begin
            run_xfer(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 2)), 0);
        end
        run_xfer(1000, 1030, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
